// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: bundles the receive-side strobe, the consumer handshake
// and the status/overflow signals of uart_rx_fifo.
//   slave  : the FIFO itself (takes i_*, drives o_*)
//   master : the environment around it (receiver + consumer)
interface uart_rx_fifo_if #(
   parameter int DLEN  = 8,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic            i_rvalid;
   logic [DLEN-1:0] i_rdata;
   logic            o_tvalid;
   logic            i_tready;
   logic [DLEN-1:0] o_tdata;
   logic [CW-1:0]   o_count;
   logic            o_full;
   logic            o_overflow;
   logic            i_ovf_clr;

   modport slave (
      input  i_rvalid, i_rdata, i_tready, i_ovf_clr,
      output o_tvalid, o_tdata, o_count, o_full, o_overflow
   );

   modport master (
      output i_rvalid, i_rdata, i_tready, i_ovf_clr,
      input  o_tvalid, o_tdata, o_count, o_full, o_overflow
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: receive buffer behind a UART receiver. Each one-cycle
// received-byte strobe is written into a circular buffer; bytes leave over a
// first-word-fall-through valid/ready handshake. The receiver cannot be
// stalled, so a strobe that finds the buffer full (and no read freeing a
// slot) is dropped and recorded in a sticky overflow flag.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   bus.i_rvalid/rdata received-byte strobe and data
//   bus.o_tvalid/tdata head entry available / head entry
//   bus.i_tready       consumer accepts head entry
//   bus.o_count        occupancy 0..DEPTH
//   bus.o_full         occupancy == DEPTH
//   bus.o_overflow     sticky dropped-write flag, cleared by bus.i_ovf_clr
module uart_rx_fifo #(
   parameter int DLEN  = 8,
   parameter int DEPTH = 16
) (
   input  logic            clk,
   input  logic            rstn,
   uart_rx_fifo_if.slave   bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_rx_fifo: DEPTH must be a power of two >= 2");
   end

   logic [DLEN-1:0] mem [DEPTH];
   logic [AW-1:0]   wptr, rptr;
   logic [CW-1:0]   count;
   logic            ovf;
   logic            tvalid, full;
   logic            wr, rd, drop;

   // Status flags come only from registered count, so there is no
   // combinational path from any input to o_tvalid / o_full.
   assign tvalid = (count != '0);
   assign full   = (count == CW'(DEPTH));

   assign rd   = tvalid && bus.i_tready;
   // A read in the same cycle frees the head slot, so a full buffer can
   // still take the incoming byte.
   assign wr   = bus.i_rvalid && (!full || rd);
   assign drop = bus.i_rvalid && full && !rd;

   // Storage carries no reset; contents are qualified by count.
   always_ff @(posedge clk) begin
      if (wr) mem[wptr] <= bus.i_rdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         ovf   <= 1'b0;
      end else begin
         if (wr) wptr <= wptr + AW'(1);
         if (rd) rptr <= rptr + AW'(1);
         if (wr && !rd)      count <= count + CW'(1);
         else if (rd && !wr) count <= count - CW'(1);
         // A drop in the same cycle as a clear keeps the flag set.
         if (drop)               ovf <= 1'b1;
         else if (bus.i_ovf_clr) ovf <= 1'b0;
      end
   end

   assign bus.o_tvalid   = tvalid;
   assign bus.o_tdata    = mem[rptr];
   assign bus.o_count    = count;
   assign bus.o_full     = full;
   assign bus.o_overflow = ovf;

   a_count_max : assert property (@(posedge clk) disable iff (!rstn)
      count <= CW'(DEPTH));
   a_no_empty_rd : assert property (@(posedge clk) disable iff (!rstn)
      rd |-> (count != '0));
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed test of uart_rx_fifo with DEPTH=4, DLEN=8.
module tb_uart_rx_fifo;
   localparam int DLEN  = 8;
   localparam int DEPTH = 4;

   logic clk;
   logic rstn;
   int   n_chk;
   int   n_err;

   uart_rx_fifo_if #(.DLEN(DLEN), .DEPTH(DEPTH)) bus ();

   uart_rx_fifo #(.DLEN(DLEN), .DEPTH(DEPTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Apply inputs for one clock edge, then return strobes to idle and leave
   // time at edge+1 so outputs are sampled away from the edge.
   task automatic step(input logic rv, input logic [DLEN-1:0] d,
                       input logic tr, input logic clr);
      bus.i_rvalid  = rv;
      bus.i_rdata   = d;
      bus.i_tready  = tr;
      bus.i_ovf_clr = clr;
      @(posedge clk);
      #1;
      bus.i_rvalid  = 1'b0;
      bus.i_tready  = 1'b0;
      bus.i_ovf_clr = 1'b0;
   endtask

   task automatic fill4(input logic [DLEN-1:0] base);
      for (int i = 0; i < 4; i++) step(1'b1, base + DLEN'(i), 1'b0, 1'b0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DLEN-1:0] q[$];
      logic [DLEN-1:0] exp_drain[4];
      int              popped;
      n_chk = 0;
      n_err = 0;
      bus.i_rvalid  = 1'b0;
      bus.i_rdata   = '0;
      bus.i_tready  = 1'b0;
      bus.i_ovf_clr = 1'b0;
      rstn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_tvalid", int'(bus.o_tvalid), 0);
      chk("rst_count", int'(bus.o_count), 0);
      chk("rst_full", int'(bus.o_full), 0);
      chk("rst_ovf", int'(bus.o_overflow), 0);
      rstn = 1'b1;
      @(posedge clk);
      #1;

      // single byte, 1-cycle latency, then read it
      step(1'b1, 8'hA5, 1'b0, 1'b0);
      chk("t1_tvalid", int'(bus.o_tvalid), 1);
      chk("t1_tdata", int'(bus.o_tdata), 'hA5);
      chk("t1_count", int'(bus.o_count), 1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t1_tvalid_rd", int'(bus.o_tvalid), 0);
      chk("t1_count_rd", int'(bus.o_count), 0);

      // tready while empty is ignored
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("empty_rd_count", int'(bus.o_count), 0);

      // fill, overflow, drain
      fill4(8'h01);
      chk("t2_full", int'(bus.o_full), 1);
      chk("t2_count", int'(bus.o_count), 4);
      chk("t2_ovf0", int'(bus.o_overflow), 0);
      step(1'b1, 8'h05, 1'b0, 1'b0);
      chk("t2_ovf", int'(bus.o_overflow), 1);
      chk("t2_count_drop", int'(bus.o_count), 4);
      for (int i = 1; i <= 4; i++) begin
         chk($sformatf("t2_drain%0d", i), int'(bus.o_tdata), i);
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("t2_empty", int'(bus.o_tvalid), 0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t2_ovf_clr", int'(bus.o_overflow), 0);

      // full + simultaneous read and write
      fill4(8'h01);
      step(1'b1, 8'h55, 1'b1, 1'b0);
      chk("t3_ovf", int'(bus.o_overflow), 0);
      chk("t3_count", int'(bus.o_count), 4);
      chk("t3_full", int'(bus.o_full), 1);
      exp_drain = '{8'h02, 8'h03, 8'h04, 8'h55};
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("t3_drain%0d", i), int'(bus.o_tdata), int'(exp_drain[i]));
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("t3_count_end", int'(bus.o_count), 0);

      // head stays stable while writes land behind it
      step(1'b1, 8'h31, 1'b0, 1'b0);
      step(1'b1, 8'h32, 1'b0, 1'b0);
      chk("stable_tdata", int'(bus.o_tdata), 'h31);
      // empty + write + ready in the same cycle: no read happens
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b1, 8'h44, 1'b1, 1'b0);
      chk("empty_wr_rd_count", int'(bus.o_count), 1);
      chk("empty_wr_rd_tdata", int'(bus.o_tdata), 'h44);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // wrap-around: write on even cycles, read on odd cycles
      popped = 0;
      for (int c = 0; c < 20; c++) begin
         logic rv, tr;
         rv = (c % 2 == 0);
         tr = (c % 2 == 1);
         if (tr && q.size() != 0) begin
            chk($sformatf("wrap_tdata%0d", popped), int'(bus.o_tdata), int'(q[0]));
            void'(q.pop_front());
            popped++;
         end
         if (rv) q.push_back(8'h10 + DLEN'(c / 2));
         step(rv, 8'h10 + DLEN'(c / 2), tr, 1'b0);
      end
      chk("wrap_popped", popped, 10);
      chk("wrap_count", int'(bus.o_count), 0);
      chk("wrap_ovf", int'(bus.o_overflow), 0);

      // overflow clear vs. simultaneous drop
      fill4(8'h60);
      step(1'b1, 8'h66, 1'b0, 1'b0);
      chk("t5_ovf_set", int'(bus.o_overflow), 1);
      step(1'b1, 8'h67, 1'b0, 1'b1);
      chk("t5_set_wins", int'(bus.o_overflow), 1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      chk("t5_clr", int'(bus.o_overflow), 0);
      chk("t5_head", int'(bus.o_tdata), 'h60);

      // async reset mid-drain with count=3 and overflow set
      step(1'b1, 8'h68, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t6_count3", int'(bus.o_count), 3);
      chk("t6_ovf1", int'(bus.o_overflow), 1);
      bus.i_tready = 1'b1;
      #2;
      rstn = 1'b0;
      #1;
      chk("t6_rst_tvalid", int'(bus.o_tvalid), 0);
      chk("t6_rst_count", int'(bus.o_count), 0);
      chk("t6_rst_full", int'(bus.o_full), 0);
      chk("t6_rst_ovf", int'(bus.o_overflow), 0);
      bus.i_tready = 1'b0;
      @(posedge clk);
      #2;
      rstn = 1'b1;
      @(posedge clk);
      #1;
      step(1'b1, 8'h7E, 1'b0, 1'b0);
      chk("t6_tvalid", int'(bus.o_tvalid), 1);
      chk("t6_tdata", int'(bus.o_tdata), 'h7E);
      chk("t6_count", int'(bus.o_count), 1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
